layer_sequencer: RTL and testbench

- Parametrised successor to the fixed three-layer network controller.
- Sequences NUM_LAYERS compute layers in order. Per layer, it issues a per-layer number of read addresses under a valid/ready handshake, waits for that layer's done strobe, then advances to the next layer.
- Layer lengths are runtime inputs captured at start. Also adds abort, zero-length layers, backpressure and an optional watchdog.
- Sits between the top-level start/ready interface and the per-layer MAC engines and weight/activation memories.

---
 rtl/layer_sequencer_if.sv | 13 +
 rtl/layer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Address stream from the layer sequencer to the weight/activation memories.
// A beat transfers on a rising clk edge where addr_valid && addr_ready; while addr_valid is high and
// addr_ready low, addr and addr_valid hold. addr_valid does not wait for addr_ready.
interface layer_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;

  modport master (output addr, output addr_valid, input addr_ready);
  modport slave  (input addr, input addr_valid, output addr_ready);
endinterface

// File: rtl/layer_sequencer.sv
// Sequences NUM_LAYERS compute layers: streams each layer's read addresses, then waits for its done strobe.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int ADDR_W         = 10,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_len,
  input  logic [NUM_LAYERS-1:0]        layer_done,
  layer_sequencer_if.master            bus,
  output logic [NUM_LAYERS-1:0]        layer_run,
  output logic [IDX_W-1:0]             cur_layer,
  output logic                         busy,
  output logic                         network_ready,
  output logic                         err_timeout,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t                        state, state_n;
  logic [NUM_LAYERS*ADDR_W-1:0]  len_q, len_n;
  logic [ADDR_W-1:0]             addr_q, addr_n;
  logic                          valid_q, valid_n;
  logic [NUM_LAYERS-1:0]         run_n;
  logic [IDX_W-1:0]              cur_n;
  logic                          busy_n, nr_n, to_n;
  logic [ADDR_W-1:0]             cur_len, nxt_len;
  logic                          done_hit, clear_all, wd_hold, wd_expired;

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign state_dbg      = state;

  // layer_run is one-hot of cur_layer, so masking avoids indexing by cur_layer.
  assign done_hit = |(layer_done & layer_run);
  assign cur_len  = ADDR_W'(len_q >> (int'(cur_layer) * ADDR_W));
  assign nxt_len  = ADDR_W'(len_q >> ((int'(cur_layer) + 1) * ADDR_W));

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Cleared on every WAIT entry (wd_hold is low on the entering cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_hold ? wd_q + WD_W'(1) : '0;
  end
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_wd;
  assign unused_wd  = wd_hold ^ (TIMEOUT_CYCLES == 0);
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    addr_n    = addr_q;
    valid_n   = valid_q;
    run_n     = layer_run;
    cur_n     = cur_layer;
    busy_n    = busy;
    nr_n      = 1'b0;
    to_n      = 1'b0;
    wd_hold   = 1'b0;
    clear_all = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          len_n  = layer_len;
          cur_n  = '0;
          addr_n = '0;
          run_n  = NUM_LAYERS'(1);
          busy_n = 1'b1;
          if (layer_len[ADDR_W-1:0] != '0) begin
            state_n = S_RUN;
            valid_n = 1'b1;
          end else begin
            state_n = S_WAIT;
            valid_n = 1'b0;
          end
        end
      end
      S_RUN, S_WAIT: begin
        // The done strobe outranks a same-cycle handshake: the layer ends without an increment.
        if (done_hit) begin
          if (cur_layer == IDX_W'(NUM_LAYERS - 1)) begin
            state_n = S_DONE;
            run_n   = '0;
            valid_n = 1'b0;
            nr_n    = 1'b1;
          end else begin
            cur_n  = cur_layer + IDX_W'(1);
            addr_n = '0;
            run_n  = layer_run << 1;
            if (nxt_len != '0) begin
              state_n = S_RUN;
              valid_n = 1'b1;
            end else begin
              state_n = S_WAIT;
              valid_n = 1'b0;
            end
          end
        end else if (state == S_RUN) begin
          if (bus.addr_ready) begin
            if (addr_q == cur_len - ADDR_W'(1)) begin
              state_n = S_WAIT;
              valid_n = 1'b0;
            end else begin
              addr_n = addr_q + ADDR_W'(1);
            end
          end
        end else if (wd_expired) begin
          clear_all = 1'b1;
          to_n      = 1'b1;
        end else begin
          wd_hold = 1'b1;
        end
      end
      S_DONE: clear_all = 1'b1;
      default: clear_all = 1'b1;
    endcase
    if (abort && state != S_IDLE) begin
      clear_all = 1'b1;
      to_n      = 1'b0;
      nr_n      = 1'b0;
    end
    if (clear_all) begin
      state_n = S_IDLE;
      addr_n  = '0;
      valid_n = 1'b0;
      run_n   = '0;
      cur_n   = '0;
      busy_n  = 1'b0;
      wd_hold = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      len_q         <= '0;
      addr_q        <= '0;
      valid_q       <= 1'b0;
      layer_run     <= '0;
      cur_layer     <= '0;
      busy          <= 1'b0;
      network_ready <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      len_q         <= len_n;
      addr_q        <= addr_n;
      valid_q       <= valid_n;
      layer_run     <= run_n;
      cur_layer     <= cur_n;
      busy          <= busy_n;
      network_ready <= nr_n;
      err_timeout   <= to_n;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised scoreboard bench for layer_sequencer: a list-based model predicts the address stream,
// a negedge monitor pops and compares every handshake and layer advance.
module tb_layer_sequencer;
  localparam int NL = 3;
  localparam int AW = 10;
  localparam int IW = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst, start, abort;
  logic [NL*AW-1:0] layer_len;
  logic [NL-1:0]  layer_done, layer_run;
  logic [IW-1:0]  cur_layer;
  logic           busy, network_ready, err_timeout;
  logic [1:0]     state_dbg;

  layer_sequencer_if #(.ADDR_W(AW)) bus ();

  layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer_len(layer_len),
    .layer_done(layer_done), .bus(bus), .layer_run(layer_run), .cur_layer(cur_layer),
    .busy(busy), .network_ready(network_ready), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [IW+AW-1:0] exp_q[$];
  int nr_seen = 0;
  int to_seen = 0;
  int len_m[NL];
  int trunc_m[NL];
  int ab_layer = -1;
  int ab_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NL-1:0] v);
    int r = -1;
    for (int i = 0; i < NL; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic          pend_stall = 1'b0, pend_adv = 1'b0;
  logic [AW-1:0] stall_addr;
  int            adv_k;
  logic [IW+AW-1:0] item;
  logic [NL-1:0] exp_run;

  always @(negedge clk) begin
    if (rst) begin
      pend_stall = 1'b0;
      pend_adv   = 1'b0;
    end else begin
      if (pend_stall) begin
        chk("stall_addr_hold", bus.addr, stall_addr);
        chk("stall_valid_hold", bus.addr_valid, 1);
      end
      if (pend_adv) begin
        if (adv_k == NL - 1) begin
          chk("adv_last_nr", network_ready, 1);
        end else begin
          chk("adv_cur_layer", cur_layer, adv_k + 1);
          chk("adv_addr_zero", bus.addr, 0);
          exp_run = NL'(1) << (adv_k + 1);
          chk("adv_layer_run", layer_run, exp_run);
          chk("adv_valid", bus.addr_valid, len_m[adv_k+1] != 0);
        end
      end
      pend_stall = 1'b0;
      pend_adv   = 1'b0;
      if (network_ready) begin
        nr_seen++;
        chk("nr_queue_drained", exp_q.size(), 0);
        chk("nr_busy", busy, 1);
        chk("nr_layer_run", layer_run, 0);
      end
      if (err_timeout) to_seen++;
      if (!abort) begin
        if (|(layer_done & layer_run)) begin
          pend_adv = 1'b1;
          adv_k    = onehot_idx(layer_run);
        end else if (bus.addr_valid && bus.addr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_handshake", bus.addr, '1);
          end else begin
            item = exp_q.pop_front();
            chk("hs_layer", cur_layer, item[IW+AW-1:AW]);
            chk("hs_addr", bus.addr, item[AW-1:0]);
            exp_run = NL'(1) << item[IW+AW-1:AW];
            chk("hs_layer_run", layer_run, exp_run);
          end
        end else if (bus.addr_valid) begin
          pend_stall = 1'b1;
          stall_addr = bus.addr;
        end
      end
    end
  end

  // ---------------- model / drivers ----------------
  task automatic set_lens(input int a, input int b, input int c);
    len_m[0] = a; len_m[1] = b; len_m[2] = c;
    for (int k = 0; k < NL; k++) trunc_m[k] = -1;
  endtask

  // Expected beat list: each layer's 0..n-1, n shortened by early done or by abort.
  task automatic build_expected();
    int n;
    for (int k = 0; k < NL; k++) begin
      n = len_m[k];
      if (trunc_m[k] >= 0 && trunc_m[k] < n) n = trunc_m[k];
      if (k == ab_layer && ab_addr < n) n = ab_addr;
      for (int a = 0; a < n; a++) exp_q.push_back({IW'(k), AW'(a)});
      if (k == ab_layer) break;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_valid"}, bus.addr_valid, 0);
    chk({tag, "_run"}, layer_run, 0);
    chk({tag, "_cur"}, cur_layer, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nr"}, network_ready, 0);
  endtask

  task automatic run_seq(input int mode, input int dmin, input int dmax, input bit stray, input bit chaos);
    int  k, last_k, wcnt, dly, nr0;
    bit  finished, tog;
    nr0 = nr_seen;
    finished = 1'b0;
    tog = 1'b1;
    build_expected();
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) layer_len[i*AW +: AW] = AW'(len_m[i]);
    start = 1'b1; abort = 1'b0; layer_done = '0;
    bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cur", cur_layer, 0);
    chk("start_run", layer_run, 1);
    chk("start_valid", bus.addr_valid, len_m[0] != 0);
    last_k = -2; wcnt = 0; dly = 0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      k = onehot_idx(layer_run);
      if (k != last_k) begin
        last_k = k; wcnt = 0; dly = $urandom_range(dmin, dmax);
      end
      layer_done = '0;
      abort = 1'b0;
      if (k >= 0) begin
        if (k == ab_layer && bus.addr_valid && bus.addr == AW'(ab_addr)) abort = 1'b1;
        else if (bus.addr_valid && trunc_m[k] >= 0 && bus.addr == AW'(trunc_m[k])) layer_done[k] = 1'b1;
        else if (!bus.addr_valid) begin
          if (wcnt >= dly) layer_done[k] = 1'b1;
          wcnt++;
        end
      end
      case (mode)
        0: bus.addr_ready = 1'b1;
        1: begin bus.addr_ready = tog; tog = ~tog; end
        default: bus.addr_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (stray && $urandom_range(0, 3) == 0) layer_done = layer_done | (NL'($urandom) & ~layer_run);
      if (chaos) begin
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) layer_len = (NL*AW)'({$urandom, $urandom});
      end
      @(posedge clk); #1;
      if (abort) begin
        abort = 1'b0; layer_done = '0; start = 1'b0;
        check_idle("abort");
        finished = 1'b1;
      end else if (network_ready) begin
        layer_done = '0; start = 1'b0;
        @(posedge clk); #1;
        chk("done_busy_drop", busy, 0);
        chk("done_nr_pulse", network_ready, 0);
        finished = 1'b1;
      end
    end
    abort = 1'b0; layer_done = '0; start = 1'b0;
    if (!finished) begin
      chk("run_budget", 0, 1);
      rst = 1'b1; #1; rst = 1'b0;
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("run_queue_empty", exp_q.size(), 0);
    chk("run_nr_count", nr_seen - nr0, (ab_layer < 0) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt, nr0, to0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; layer_done = '0; layer_len = '0;
    bus.addr_ready = 1'b0;
    #1;
    check_idle("reset");
    chk("reset_to", err_timeout, 0);
    chk("reset_state", state_dbg, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full network, always ready, done one cycle after WAIT entry
    set_lens(784, 128, 32); run_seq(0, 1, 1, 0, 0);
    // backpressure with alternating ready
    set_lens(4, 3, 2); run_seq(1, 0, 2, 0, 0);
    // zero-length middle layer
    set_lens(5, 0, 3); run_seq(0, 0, 2, 0, 0);
    // early done at addr 10 with stray strobes on inactive layers
    set_lens(784, 128, 32); trunc_m[0] = 10; run_seq(0, 0, 1, 1, 0);
    // abort in layer 1 at addr 50, then a clean run
    set_lens(60, 128, 32); ab_layer = 1; ab_addr = 50; run_seq(0, 0, 1, 0, 0);
    ab_layer = -1;
    set_lens(7, 9, 11); run_seq(2, 0, 2, 0, 0);
    // single-beat and maximum-length layers
    set_lens(1, 0, 1023); run_seq(0, 0, 0, 0, 0);

    // asynchronous reset in the middle of RUN
    set_lens(20, 20, 20); build_expected();
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) layer_len[i*AW +: AW] = AW'(len_m[i]);
    start = 1'b1; bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!(bus.addr_valid && bus.addr == AW'(5)) && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("rst_reach_addr5", bus.addr, 5);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    chk("async_rst_state", state_dbg, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    // watchdog: layer 0 done withheld
    set_lens(3, 2, 2); ab_layer = 0; ab_addr = 3; build_expected(); ab_layer = -1;
    nr0 = nr_seen; to0 = to_seen;
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) layer_len[i*AW +: AW] = AW'(len_m[i]);
    start = 1'b1; bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!(!bus.addr_valid && layer_run == NL'(1)) && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("wd_wait_entry", {bus.addr_valid, layer_run}, {1'b0, NL'(1)});
`ifdef LAYER_SEQ_TIMEOUT_EN
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!err_timeout && cnt < 100);
    chk("wd_cycles", cnt, TO);
    chk("wd_busy", busy, 0);
    chk("wd_run", layer_run, 0);
    chk("wd_nr", network_ready, 0);
    @(posedge clk); #1;
    chk("wd_pulse_width", err_timeout, 0);
    chk("wd_pulses", to_seen - to0, 1);
`else
    repeat (40) @(posedge clk);
    #1;
    chk("nowd_still_wait", {busy, bus.addr_valid, layer_run}, {1'b1, 1'b0, NL'(1)});
    chk("nowd_no_pulse", to_seen - to0, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle("nowd_abort");
`endif
    chk("wd_no_nr", nr_seen - nr0, 0);
    chk("wd_queue_empty", exp_q.size(), 0);

    // randomised runs
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NL; k++) begin
        len_m[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
        trunc_m[k] = (len_m[k] > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len_m[k] - 1) : -1;
      end
      run_seq(2, 0, 3, 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
